// File: rtl/rom_pkg.sv
// Shared constants and FSM encoding for the instruction ROM server.
package rom_pkg;
  localparam int unsigned ROM_ADDR_W = 6;
  localparam int unsigned ROM_DATA_W = 16;
  localparam int unsigned ROM_DEPTH  = 2 ** ROM_ADDR_W;
  localparam int unsigned ROM_CNT_W  = ROM_ADDR_W + 1;

  localparam logic [ROM_DATA_W-1:0] EOE_WORD = 16'hFF00;

  typedef enum logic [1:0] {
    StEmpty  = 2'd0,
    StLoadHi = 2'd1,
    StLoadLo = 2'd2,
    StReady  = 2'd3
  } rom_state_e;
endpackage

// File: rtl/instr_rom_server_if.sv
// Fetch and byte-loader signals of the ROM server; master is the requester side.
interface instr_rom_server_if;
  import rom_pkg::*;

  logic                  enable_to_rom;
  logic [ROM_ADDR_W-1:0] address_to_rom;
  logic [ROM_DATA_W-1:0] data_from_rom;
  logic                  load_start;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_ready;
  logic                  rom_ready;
  logic [ROM_CNT_W-1:0]  load_count;
  logic                  load_error;

  modport master (
    output enable_to_rom, address_to_rom, load_start, load_valid, load_byte,
    input  data_from_rom, load_ready, rom_ready, load_count, load_error
  );

  modport slave (
    input  enable_to_rom, address_to_rom, load_start, load_valid, load_byte,
    output data_from_rom, load_ready, rom_ready, load_count, load_error
  );
endinterface

// File: rtl/rom_word_array.sv
// Register-based word store: one write port, one registered read port that holds
// its output while re_i is low. Reset fills every word and the read register.
module rom_word_array
  import rom_pkg::*;
#(
  parameter int unsigned          AddrW    = ROM_ADDR_W,
  parameter int unsigned          DataW    = ROM_DATA_W,
  parameter logic [DataW-1:0]     FillWord = EOE_WORD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);
  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];
  logic [DataW-1:0] rdata_q, rdata_d;

  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '{default: FillWord};
      rdata_q <= FillWord;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_rom_server.sv
// Instruction ROM server: byte-pair program loader FSM feeding a 64-word store,
// and a 1-cycle fetch port that returns EOE_WORD until the program is loaded.
module instr_rom_server
  import rom_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  instr_rom_server_if.slave  bus
);
  rom_state_e           state_q, state_d;
  logic [7:0]           hi_q, hi_d;
  logic [ROM_CNT_W-1:0] count_q, count_d;
  logic                 err_q, err_d;
  logic                 gated_q, gated_d;

  logic                  we;
  logic [ROM_DATA_W-1:0] wdata;
  logic                  re;
  logic [ROM_DATA_W-1:0] rdata;

  assign wdata = {hi_q, bus.load_byte};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    count_d = count_q;
    err_d   = err_q;
    we      = 1'b0;
    // A restart wins over any same-cycle byte and drops a half-assembled word.
    if (bus.load_start) begin
      state_d = StLoadHi;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StLoadHi: begin
          if (bus.load_valid) begin
            hi_d    = bus.load_byte;
            state_d = StLoadLo;
          end
        end
        StLoadLo: begin
          if (bus.load_valid) begin
            we      = 1'b1;
            count_d = (count_q == ROM_CNT_W'(ROM_DEPTH)) ? count_q : count_q + 1'b1;
            if (wdata == EOE_WORD) begin
              state_d = StReady;
            end else if (count_q == ROM_CNT_W'(ROM_DEPTH - 1)) begin
              state_d = StReady;
              err_d   = 1'b1;
            end else begin
              state_d = StLoadHi;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Fetches before the program is ready must see EOE_WORD so the core halts.
  always_comb begin
    re      = bus.enable_to_rom && (state_q == StReady);
    gated_d = gated_q;
    if (bus.enable_to_rom) gated_d = (state_q != StReady);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      hi_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      err_q   <= err_d;
      gated_q <= gated_d;
    end
  end

  rom_word_array #(
    .AddrW    (ROM_ADDR_W),
    .DataW    (ROM_DATA_W),
    .FillWord (EOE_WORD)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (we),
    .waddr_i (count_q[ROM_ADDR_W-1:0]),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (bus.address_to_rom),
    .rdata_o (rdata)
  );

  assign bus.data_from_rom = gated_q ? EOE_WORD : rdata;
  assign bus.load_ready    = (state_q == StLoadHi) || (state_q == StLoadLo);
  assign bus.rom_ready     = (state_q == StReady);
  assign bus.load_count    = count_q;
  assign bus.load_error    = err_q;
endmodule
